// File: rtl/risc16_core.sv
// risc16_core: single-cycle 16-bit RiSC-16 processor core.
// Executes one instruction per clock. Instruction and data memories are external.
// Ports:
//   i_clk          clock; all state updates on the rising edge
//   i_rst          synchronous active-high reset
//   i_inst         instruction word at o_pc (combinational)
//   o_pc           current PC, word address (registered)
//   i_mem_rd_data  data memory read data for o_mem_addr (same cycle)
//   o_mem_wr_data  store data, always R[rA] (combinational)
//   o_mem_addr     R[rB] + sext(imm7), every opcode (combinational)
//   o_mem_wr_en    high only for SW and never while i_rst is high (combinational)
module risc16_core #(
    parameter logic [15:0] p_RESET_PC = 16'h0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_inst,
    output logic [15:0] o_pc,
    input  logic [15:0] i_mem_rd_data,
    output logic [15:0] o_mem_wr_data,
    output logic [15:0] o_mem_addr,
    output logic        o_mem_wr_en
);

    localparam int unsigned DW    = 16;
    localparam int unsigned RW    = 3;
    localparam int unsigned NREG  = 8;
    localparam int unsigned IMM7W = 7;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_ADDI = 3'b001,
        OP_NAND = 3'b010,
        OP_LUI  = 3'b011,
        OP_SW   = 3'b100,
        OP_LW   = 3'b101,
        OP_BEQ  = 3'b110,
        OP_JALR = 3'b111
    } op_e;

    // Architectural state; R0 has no storage. Power-up values are zero.
    logic [DW-1:0] r_pc = '0;
    logic [DW-1:0] r_regs [1:NREG-1] = '{default: '0};

    // Instruction fields
    op_e           w_op;
    logic [RW-1:0] w_ra;
    logic [RW-1:0] w_rb;
    logic [RW-1:0] w_rc;
    logic [DW-1:0] w_simm7;
    logic [9:0]    w_imm10;

    assign w_op    = op_e'(i_inst[15:13]);
    assign w_ra    = i_inst[12:10];
    assign w_rb    = i_inst[9:7];
    assign w_rc    = i_inst[2:0];
    assign w_imm10 = i_inst[9:0];
    assign w_simm7 = {{(DW-IMM7W){i_inst[6]}}, i_inst[6:0]};

    // Read view of the register file with R0 hard-wired to zero
    logic [DW-1:0] w_rf [0:NREG-1];

    always_comb begin
        w_rf[0] = '0;
        for (int i = 1; i < int'(NREG); i++) begin
            w_rf[i] = r_regs[i];
        end
    end

    logic [DW-1:0] w_ra_val;
    logic [DW-1:0] w_rb_val;
    logic [DW-1:0] w_rc_val;

    assign w_ra_val = w_rf[w_ra];
    assign w_rb_val = w_rf[w_rb];
    assign w_rc_val = w_rf[w_rc];

    // Effective address is computed for every opcode; only the write enable is qualified
    logic [DW-1:0] w_addr;
    logic [DW-1:0] w_pc_inc;

    assign w_addr   = w_rb_val + w_simm7;
    assign w_pc_inc = r_pc + DW'(1);

    // Execute: register write-back and next PC
    logic          w_rf_we;
    logic [DW-1:0] w_wb_data;
    logic [DW-1:0] w_pc_next;

    always_comb begin
        w_rf_we   = 1'b0;
        w_wb_data = '0;
        w_pc_next = w_pc_inc;
        unique case (w_op)
            OP_ADD: begin
                w_rf_we   = 1'b1;
                w_wb_data = w_rb_val + w_rc_val;
            end
            OP_ADDI: begin
                w_rf_we   = 1'b1;
                w_wb_data = w_rb_val + w_simm7;
            end
            OP_NAND: begin
                w_rf_we   = 1'b1;
                w_wb_data = ~(w_rb_val & w_rc_val);
            end
            OP_LUI: begin
                w_rf_we   = 1'b1;
                w_wb_data = {w_imm10, 6'b0};
            end
            OP_SW: begin
                w_rf_we   = 1'b0;
            end
            OP_LW: begin
                w_rf_we   = 1'b1;
                w_wb_data = i_mem_rd_data;
            end
            OP_BEQ: begin
                if (w_ra_val == w_rb_val) begin
                    w_pc_next = w_pc_inc + w_simm7;
                end
            end
            OP_JALR: begin
                // Target comes from the pre-write R[rB], so rA == rB is safe
                w_rf_we   = 1'b1;
                w_wb_data = w_pc_inc;
                w_pc_next = w_rb_val;
            end
            default: begin
                w_rf_we   = 1'b0;
            end
        endcase
    end

    // PC and register file update
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc <= p_RESET_PC;
            for (int i = 1; i < int'(NREG); i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_pc <= w_pc_next;
            for (int i = 1; i < int'(NREG); i++) begin
                if (w_rf_we && (w_ra == RW'(i))) begin
                    r_regs[i] <= w_wb_data;
                end
            end
        end
    end

    assign o_pc          = r_pc;
    assign o_mem_addr    = w_addr;
    assign o_mem_wr_data = w_ra_val;
    assign o_mem_wr_en   = (w_op == OP_SW) && !i_rst;

endmodule

// File: tb/tb_risc16_core.sv
// Self-checking bench for risc16_core: directed program steps followed by random
// instructions, all compared against an instruction-level reference model.
module tb_risc16_core;

    logic        clk;
    logic        rst;
    logic [15:0] inst;
    logic [15:0] pc;
    logic [15:0] rd_data;
    logic [15:0] wr_data;
    logic [15:0] addr;
    logic        wr_en;

    risc16_core #(.p_RESET_PC(16'h0000)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_inst        (inst),
        .o_pc          (pc),
        .i_mem_rd_data (rd_data),
        .o_mem_wr_data (wr_data),
        .o_mem_addr    (addr),
        .o_mem_wr_en   (wr_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: architectural state of the machine
    logic [15:0] m_pc;
    logic [15:0] m_r [8];
    logic [15:0] m_mem [bit [15:0]];

    logic [15:0] cur_inst;
    logic        cur_rst;
    logic [15:0] cur_rd;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] sx7(input logic [6:0] v);
        return 16'($signed(v));
    endfunction

    // Unwritten memory returns an address-dependent pattern
    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        if (m_mem.exists(a)) return m_mem[a];
        return a ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] rri(input int op, input int ra, input int rb, input logic [6:0] imm);
        return {3'(op), 3'(ra), 3'(rb), imm};
    endfunction

    function automatic logic [15:0] rrr(input int op, input int ra, input int rb, input int rc);
        return {3'(op), 3'(ra), 3'(rb), 4'b0, 3'(rc)};
    endfunction

    function automatic logic [15:0] ri(input int op, input int ra, input logic [9:0] imm);
        return {3'(op), 3'(ra), imm};
    endfunction

    function automatic void m_wr(input int idx, input logic [15:0] v);
        if (idx != 0) m_r[idx] = v;
    endfunction

    // Drive one instruction and check all outputs against the model
    task automatic present(input logic [15:0] ins, input logic r);
        int op, ra, rb;
        logic [15:0] ea;
        op = int'(ins[15:13]);
        ra = int'(ins[12:10]);
        rb = int'(ins[9:7]);
        ea = m_r[rb] + sx7(ins[6:0]);
        cur_inst = ins;
        cur_rst  = r;
        cur_rd   = mem_rd(ea);
        inst     = ins;
        rst      = r;
        rd_data  = cur_rd;
        #1;
        chk("pc", pc, m_pc);
        chk("mem_addr", addr, ea);
        chk("mem_wr_data", wr_data, m_r[ra]);
        chk("mem_wr_en", {15'b0, wr_en}, {15'b0, (op == 4) && !r});
    endtask

    // Advance the model by one instruction, then clock the DUT
    task automatic commit();
        int op, ra, rb, rc;
        logic [15:0] sx, a, b, nxt, tgt;
        op  = int'(cur_inst[15:13]);
        ra  = int'(cur_inst[12:10]);
        rb  = int'(cur_inst[9:7]);
        rc  = int'(cur_inst[2:0]);
        sx  = sx7(cur_inst[6:0]);
        a   = m_r[ra];
        b   = m_r[rb];
        nxt = m_pc + 16'd1;
        if (cur_rst) begin
            m_pc = 16'h0000;
            for (int i = 0; i < 8; i++) m_r[i] = '0;
        end else begin
            case (op)
                0: m_wr(ra, b + m_r[rc]);
                1: m_wr(ra, b + sx);
                2: m_wr(ra, ~(b & m_r[rc]));
                3: m_wr(ra, {cur_inst[9:0], 6'b0});
                4: m_mem[b + sx] = a;
                5: m_wr(ra, cur_rd);
                6: if (a == b) nxt = nxt + sx;
                default: begin
                    tgt = b;
                    m_wr(ra, nxt);
                    nxt = tgt;
                end
            endcase
            m_pc = nxt;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [15:0] ins);
        present(ins, 1'b0);
        commit();
    endtask

    // ADD R0,Rx,R0 is a no-op whose address output exposes R[x]
    task automatic probe(input int idx, input logic [15:0] exp, input string tag);
        present(rrr(0, 0, idx, 0), 1'b0);
        chk(tag, addr, exp);
        commit();
    endtask

    initial begin
        m_pc = '0;
        for (int i = 0; i < 8; i++) m_r[i] = '0;
        inst    = 16'h0000;
        rst     = 1'b1;
        rd_data = 16'h0000;

        // Reset
        present(16'h0000, 1'b1);
        commit();
        present(rri(4, 1, 0, 7'd3), 1'b1);
        chk("reset_wr_en", {15'b0, wr_en}, 16'h0000);
        commit();
        chk("reset_pc", pc, 16'h0000);

        // ADDI chain
        step(rri(1, 1, 0, 7'd5));
        chk("pc_after_1", pc, 16'd1);
        step(rri(1, 2, 1, 7'h7D));
        chk("pc_after_2", pc, 16'd2);
        probe(1, 16'd5, "addi_r1");
        probe(2, 16'd2, "addi_r2");

        // LUI / NAND / R0 write discard
        step(ri(3, 3, 10'h3FF));
        step(rri(1, 3, 3, 7'h3F));
        probe(3, 16'hFFFF, "lui_addi_r3");
        step(rrr(2, 4, 3, 3));
        probe(4, 16'h0000, "nand_r4");
        step(rrr(0, 0, 3, 3));
        probe(0, 16'h0000, "r0_zero");

        // Store then load
        step(rri(1, 1, 0, 7'd7));
        present(rri(4, 1, 0, 7'd3), 1'b0);
        chk("sw_wr_en", {15'b0, wr_en}, 16'h0001);
        chk("sw_addr", addr, 16'd3);
        chk("sw_data", wr_data, 16'd7);
        commit();
        step(rri(5, 5, 0, 7'd3));
        probe(5, 16'd7, "lw_r5");

        // Branches at PC 10
        step(rri(1, 6, 0, 7'd10));
        step(rrr(7, 0, 6, 0));
        chk("jump_to_10", pc, 16'd10);
        step(rri(6, 1, 1, 7'h7E));
        chk("beq_taken_back", pc, 16'd9);
        step(rrr(7, 0, 6, 0));
        step(rri(6, 1, 2, 7'd4));
        chk("beq_not_taken", pc, 16'd11);

        // JALR link and rA == rB
        step(rri(1, 6, 0, 7'd20));
        step(rri(1, 5, 0, 7'd4));
        step(rrr(7, 0, 5, 0));
        chk("jump_to_4", pc, 16'd4);
        step(rrr(7, 7, 6, 0));
        chk("jalr_pc", pc, 16'd20);
        probe(7, 16'd5, "jalr_link_r7");
        step(rrr(7, 6, 6, 0));
        chk("jalr_same_pc", pc, 16'd20);
        probe(6, 16'd22, "jalr_same_r6");

        // PC and branch-target wrap
        step(ri(3, 1, 10'h3FF));
        step(rri(1, 1, 1, 7'h3F));
        step(rrr(7, 0, 1, 0));
        chk("pc_at_ffff", pc, 16'hFFFF);
        step(rri(1, 2, 0, 7'd1));
        chk("pc_wrap", pc, 16'h0000);
        step(rri(6, 0, 0, 7'h7E));
        chk("branch_wrap", pc, 16'hFFFF);

        // Mid-program reset with a store presented
        present(rri(4, 1, 0, 7'd3), 1'b1);
        chk("rst_sw_wr_en", {15'b0, wr_en}, 16'h0000);
        commit();
        chk("rst_pc", pc, 16'h0000);
        for (int i = 1; i < 8; i++) probe(i, 16'h0000, "rst_reg");
        step(rri(5, 5, 0, 7'd3));
        probe(5, 16'd7, "mem_kept_after_rst");

        // Random instruction stream
        for (int n = 0; n < 600; n++) begin
            logic [15:0] ri_w;
            logic        rr;
            ri_w = 16'($urandom);
            // Keep many accesses in a small window so loads hit earlier stores
            if ($urandom_range(0, 1) == 0) ri_w[9:7] = 3'd0;
            rr = ($urandom_range(0, 59) == 0);
            present(ri_w, rr);
            commit();
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) probe(i, m_r[i], "final_reg");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
